// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: PC control, instruction-memory request/ack, and decode handshake.
// IFU_ALIGN_CHECK_EN adds the fetch_misaligned status output.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Program counter side
  logic              fetch_en;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic              pc_write;
  // Instruction memory side
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_req;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  // Decode side
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              if_ready;
  // Execute side
  logic              redirect;
  logic [ADDR_W-1:0] redirect_target;
`ifdef IFU_ALIGN_CHECK_EN
  logic              fetch_misaligned;
`endif

  modport master (
    input  fetch_en, pc, imem_ack, imem_rdata, if_ready, redirect, redirect_target,
`ifdef IFU_ALIGN_CHECK_EN
    output fetch_misaligned,
`endif
    output pc_next, pc_write, imem_addr, imem_req, instr, instr_pc, instr_valid
  );

  modport slave (
    output fetch_en, pc, imem_ack, imem_rdata, if_ready, redirect, redirect_target,
`ifdef IFU_ALIGN_CHECK_EN
    input  fetch_misaligned,
`endif
    input  pc_next, pc_write, imem_addr, imem_req, instr, instr_pc, instr_valid
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues req/ack fetches at the current PC, buffers one
// instruction for decode, drives the PC update controls and applies redirects.
// Optional macro IFU_ALIGN_CHECK_EN: refuse fetches from PCs that are not a
// multiple of INSTR_BYTES and flag them on fetch_misaligned.
module instr_fetch_unit #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int INSTR_BYTES = 4
) (
  input logic               clk,
  input logic               reset_n,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              valid_q, valid_d;
  logic              pc_write_c;
  logic [ADDR_W-1:0] pc_next_c;
  logic              start_fetch;
  logic              pc_misaligned;

`ifdef IFU_ALIGN_CHECK_EN
  logic              misal_q, misal_d;
  assign pc_misaligned = (bus.pc % ADDR_W'(INSTR_BYTES)) != '0;
`else
  assign pc_misaligned = 1'b0;
`endif

  // Next-state, fetch bookkeeping and combinational PC controls
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    valid_d     = valid_q;
    pc_write_c  = 1'b0;
    pc_next_c   = bus.pc;
    start_fetch = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
    misal_d     = misal_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.redirect) begin
          pc_write_c = 1'b1;
          pc_next_c  = bus.redirect_target;
        end else if (bus.fetch_en) begin
          start_fetch = 1'b1;
        end
      end

      FETCH: begin
        if (bus.redirect) begin
          // Redirect wins over the sequential increment; a response arriving
          // now is dropped, otherwise the pending one is drained later.
          pc_write_c = 1'b1;
          pc_next_c  = bus.redirect_target;
          if (bus.imem_ack) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end else if (bus.imem_ack) begin
          instr_d    = bus.imem_rdata;
          instr_pc_d = addr_q;
          valid_d    = 1'b1;
          req_d      = 1'b0;
          pc_write_c = 1'b1;
          pc_next_c  = addr_q + ADDR_W'(INSTR_BYTES);
          state_d    = VALID;
        end
      end

      VALID: begin
        if (bus.redirect) begin
          // Buffered instruction is on the wrong path: squash it.
          pc_write_c = 1'b1;
          pc_next_c  = bus.redirect_target;
          valid_d    = 1'b0;
          state_d    = IDLE;
        end else if (bus.if_ready) begin
          valid_d = 1'b0;
          if (bus.fetch_en) begin
            start_fetch = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DRAIN: begin
        if (bus.redirect) begin
          pc_write_c = 1'b1;
          pc_next_c  = bus.redirect_target;
        end
        // The stale response is consumed whenever it shows up; holding DRAIN
        // past it would leave req waiting for an ack that never comes.
        if (bus.imem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Common entry into FETCH from IDLE or after a decode handshake
    if (start_fetch) begin
      if (pc_misaligned) begin
`ifdef IFU_ALIGN_CHECK_EN
        misal_d = 1'b1;
`endif
        state_d = IDLE;
      end else begin
        state_d = FETCH;
        req_d   = 1'b1;
        addr_d  = bus.pc;
      end
    end

`ifdef IFU_ALIGN_CHECK_EN
    if (bus.redirect) begin
      misal_d = 1'b0;
    end
`endif

    // PC controls are quiet while reset is held
    if (!reset_n) begin
      pc_write_c = 1'b0;
      pc_next_c  = '0;
    end
  end

  // State and buffered-instruction registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

`ifdef IFU_ALIGN_CHECK_EN
  // Misaligned-fetch status flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      misal_q <= 1'b0;
    end else begin
      misal_q <= misal_d;
    end
  end
  assign bus.fetch_misaligned = misal_q;
`endif

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc_write    = pc_write_c;
  assign bus.pc_next     = pc_next_c;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: PC register model, programmable-latency memory
// model and a scoreboard of accepted fetches compared at the decode handshake.
module tb_instr_fetch_unit;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } sb_t;

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] pc_m;
  logic [AW-1:0] prev_pc;
  logic [AW-1:0] out_addr;
  logic          req_prev;
  logic          discard;
  logic          pw_s;
  logic [AW-1:0] pn_s;
  int            mem_delay;
  int            mem_cnt;
  int            hs_count;
  int            n_tests;
  int            n_fail;
  sb_t           sb[$];

  instr_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  instr_fetch_unit dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.master)
  );

  assign bus.pc = pc_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return a ^ 32'h0000_0013;
  endfunction

  // One clock cycle: memory response, sampling and scoreboard, then the edge.
  task automatic step();
    logic          accepted;
    logic          exp_pw;
    logic [AW-1:0] exp_pn;
    logic [AW-1:0] pc_lat;
    sb_t           e;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    if (bus.imem_req && reset_n) begin
      if (mem_cnt >= mem_delay) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_fn(bus.imem_addr);
        mem_cnt        = 0;
      end else begin
        mem_cnt++;
      end
    end else begin
      mem_cnt = 0;
    end
    #1;
    pw_s = bus.pc_write;
    pn_s = bus.pc_next;
    if (!reset_n) begin
      n_tests++;
      if (bus.pc_write !== 1'b0 || bus.pc_next !== '0) begin
        n_fail++;
        $display("FAIL reset_pc_ctl: pc_write=%b pc_next=%h, required 0/0", bus.pc_write, bus.pc_next);
      end
      sb.delete();
      discard = 1'b0;
    end else begin
      if (bus.imem_req && !req_prev) begin
        n_tests++;
        if (bus.imem_addr !== prev_pc) begin
          n_fail++;
          $display("FAIL issue_addr: imem_addr=%h, required %h", bus.imem_addr, prev_pc);
        end
        out_addr = prev_pc;
      end
      n_tests++;
      if (bus.instr_valid !== (sb.size() != 0)) begin
        n_fail++;
        $display("FAIL instr_valid: got %b, required %b", bus.instr_valid, sb.size() != 0);
      end else if (bus.instr_valid) begin
        n_tests++;
        if (bus.instr !== sb[0].data || bus.instr_pc !== sb[0].pc) begin
          n_fail++;
          $display("FAIL instr_out: instr=%h pc=%h, required %h pc=%h",
                   bus.instr, bus.instr_pc, sb[0].data, sb[0].pc);
        end
      end
      if (bus.instr_valid && sb.size() != 0 && (bus.redirect || bus.if_ready)) begin
        e = sb.pop_front();
        if (bus.redirect) begin
          $display("[TB] squash   pc=%h", e.pc);
        end else begin
          hs_count++;
          $display("[TB] decode   pc=%h instr=%h", e.pc, e.data);
        end
      end
      accepted = bus.imem_ack && bus.imem_req && !bus.redirect && !discard;
      exp_pw   = bus.redirect || accepted;
      exp_pn   = bus.redirect ? bus.redirect_target : (accepted ? out_addr + 32'd4 : pc_m);
      n_tests++;
      if (bus.pc_write !== exp_pw || bus.pc_next !== exp_pn) begin
        n_fail++;
        $display("FAIL pc_ctl: pc_write=%b pc_next=%h, required %b %h",
                 bus.pc_write, bus.pc_next, exp_pw, exp_pn);
      end
      if (accepted) sb.push_back('{pc: out_addr, data: mem_fn(out_addr)});
      if (bus.imem_ack && discard) discard = 1'b0;
      else if (bus.redirect && bus.imem_req && !bus.imem_ack) discard = 1'b1;
    end
    pc_lat   = pc_m;
    req_prev = reset_n ? bus.imem_req : 1'b0;
    @(posedge clk);
    #1;
    if (pw_s) pc_m = pn_s;
    prev_pc = pc_lat;
  endtask

  task automatic wait_valid(input int budget);
    int i;
    for (i = 0; i < budget && !bus.instr_valid; i++) step();
    n_tests++;
    if (!bus.instr_valid) begin
      n_fail++;
      $display("FAIL wait_valid: instr_valid=0 after %0d cycles, required 1", budget);
    end
  endtask

  task automatic test_reset();
    reset_n             = 1'b0;
    bus.fetch_en        = 1'b0;
    bus.if_ready        = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_target = '0;
    bus.imem_ack        = 1'b0;
    bus.imem_rdata      = '0;
    mem_delay = 0;
    #2;
    for (int i = 0; i < 3; i++) step();
    n_tests++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== '0 || bus.instr !== '0 ||
        bus.instr_pc !== '0 || bus.instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: req=%b addr=%h instr=%h ipc=%h valid=%b, required all 0",
               bus.imem_req, bus.imem_addr, bus.instr, bus.instr_pc, bus.instr_valid);
    end
`ifdef IFU_ALIGN_CHECK_EN
    n_tests++;
    if (bus.fetch_misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_misaligned: got %b, required 0", bus.fetch_misaligned);
    end
`endif
  endtask

  task automatic test_first_fetch();
    bus.fetch_en = 1'b1;
    mem_delay    = 0;
    reset_n      = 1'b1;
    step();
    n_tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL first_req: req=%b addr=%h, required 1 00000000", bus.imem_req, bus.imem_addr);
    end
    bus.fetch_en = 1'b0;
    step();
    n_tests++;
    if (pw_s !== 1'b1 || pn_s !== 32'h4) begin
      n_fail++;
      $display("FAIL first_pc_next: pc_write=%b pc_next=%h, required 1 00000004", pw_s, pn_s);
    end
    n_tests++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h13 || bus.instr_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL first_instr: valid=%b instr=%h pc=%h, required 1 00000013 00000000",
               bus.instr_valid, bus.instr, bus.instr_pc);
    end
    bus.if_ready = 1'b1;
    step();
    bus.if_ready = 1'b0;
    step();
  endtask

  task automatic test_wait_states();
    int            req_cycles;
    int            pw_cnt;
    logic [AW-1:0] a0;
    mem_delay    = 3;
    a0           = pc_m;
    bus.fetch_en = 1'b1;
    step();
    bus.fetch_en = 1'b0;
    req_cycles   = 0;
    pw_cnt       = 0;
    for (int i = 0; i < 10 && bus.imem_req; i++) begin
      req_cycles++;
      n_tests++;
      if (bus.imem_addr !== a0) begin
        n_fail++;
        $display("FAIL wait_addr_stable: addr=%h, required %h", bus.imem_addr, a0);
      end
      step();
      if (pw_s) pw_cnt++;
    end
    n_tests++;
    if (req_cycles != 4 || pw_cnt != 1) begin
      n_fail++;
      $display("FAIL wait_req_len: req cycles=%0d pc_write pulses=%0d, required 4 1", req_cycles, pw_cnt);
    end
    wait_valid(2);
    bus.if_ready = 1'b1;
    step();
    bus.if_ready = 1'b0;
  endtask

  task automatic test_stall();
    mem_delay    = 0;
    bus.fetch_en = 1'b1;
    bus.if_ready = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold: req=%b valid=%b, required 0 1", bus.imem_req, bus.instr_valid);
      end
      step();
    end
    bus.if_ready = 1'b1;
    step();
    n_tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== pc_m) begin
      n_fail++;
      $display("FAIL stall_next_req: req=%b addr=%h, required 1 %h", bus.imem_req, bus.imem_addr, pc_m);
    end
    bus.fetch_en = 1'b0;
    step();
    step();
    bus.if_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int hs0;
    mem_delay    = 0;
    hs0          = hs_count;
    bus.fetch_en = 1'b1;
    bus.if_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    n_tests++;
    if (hs_count - hs0 != 3) begin
      n_fail++;
      $display("FAIL b2b_rate: %0d handshakes in 8 cycles, required 3", hs_count - hs0);
    end
    bus.fetch_en = 1'b0;
    for (int i = 0; i < 3; i++) step();
    bus.if_ready = 1'b0;
    n_tests++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: req=%b valid=%b, required 0 0", bus.imem_req, bus.instr_valid);
    end
  endtask

  task automatic test_redirect_drain();
    int i;
    mem_delay    = 3;
    bus.fetch_en = 1'b1;
    step();
    bus.fetch_en = 1'b0;
    step();
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'h100;
    step();
    bus.redirect = 1'b0;
    n_tests++;
    if (pw_s !== 1'b1 || pn_s !== 32'h100) begin
      n_fail++;
      $display("FAIL drain_redirect: pc_write=%b pc_next=%h, required 1 00000100", pw_s, pn_s);
    end
    for (i = 0; i < 10 && bus.imem_req; i++) step();
    n_tests++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || pc_m !== 32'h100) begin
      n_fail++;
      $display("FAIL drain_done: req=%b valid=%b pc=%h, required 0 0 00000100",
               bus.imem_req, bus.instr_valid, pc_m);
    end
    bus.fetch_en = 1'b1;
    step();
    bus.fetch_en = 1'b0;
    n_tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL drain_refetch: req=%b addr=%h, required 1 00000100", bus.imem_req, bus.imem_addr);
    end
    wait_valid(10);
    bus.if_ready = 1'b1;
    step();
    bus.if_ready = 1'b0;
  endtask

  task automatic test_redirect_ack();
    mem_delay    = 0;
    bus.fetch_en = 1'b1;
    step();
    bus.fetch_en        = 1'b0;
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'h200;
    step();
    bus.redirect = 1'b0;
    n_tests++;
    if (pw_s !== 1'b1 || pn_s !== 32'h200) begin
      n_fail++;
      $display("FAIL redir_ack_pc: pc_write=%b pc_next=%h, required 1 00000200", pw_s, pn_s);
    end
    step();
    n_tests++;
    if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0 || pc_m !== 32'h200) begin
      n_fail++;
      $display("FAIL redir_ack_state: valid=%b req=%b pc=%h, required 0 0 00000200",
               bus.instr_valid, bus.imem_req, pc_m);
    end
  endtask

  task automatic test_squash();
    mem_delay    = 0;
    bus.fetch_en = 1'b1;
    step();
    bus.fetch_en = 1'b0;
    step();
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'h300;
    bus.if_ready        = 1'b1;
    step();
    bus.redirect = 1'b0;
    bus.if_ready = 1'b0;
    n_tests++;
    if (bus.instr_valid !== 1'b0 || pc_m !== 32'h300) begin
      n_fail++;
      $display("FAIL squash: valid=%b pc=%h, required 0 00000300", bus.instr_valid, pc_m);
    end
    step();
    n_tests++;
    if (bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL squash_idle: req=%b, required 0", bus.imem_req);
    end
  endtask

  task automatic test_wrap();
    mem_delay           = 0;
    bus.fetch_en        = 1'b1;
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    step();
    bus.redirect = 1'b0;
    n_tests++;
    if (bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_redirect_noreq: req=%b, required 0", bus.imem_req);
    end
    step();
    bus.fetch_en = 1'b0;
    step();
    n_tests++;
    if (pw_s !== 1'b1 || pn_s !== 32'h0 || pc_m !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap: pc_write=%b pc_next=%h pc=%h, required 1 00000000 00000000", pw_s, pn_s, pc_m);
    end
    n_tests++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_instr: valid=%b pc=%h, required 1 fffffffc", bus.instr_valid, bus.instr_pc);
    end
    bus.if_ready = 1'b1;
    step();
    bus.if_ready = 1'b0;
  endtask

`ifdef IFU_ALIGN_CHECK_EN
  task automatic test_align();
    mem_delay           = 0;
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'h2;
    step();
    bus.redirect = 1'b0;
    bus.fetch_en = 1'b1;
    step();
    step();
    n_tests++;
    if (bus.imem_req !== 1'b0 || bus.fetch_misaligned !== 1'b1) begin
      n_fail++;
      $display("FAIL misaligned: req=%b flag=%b, required 0 1", bus.imem_req, bus.fetch_misaligned);
    end
    bus.fetch_en        = 1'b0;
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'h10;
    step();
    bus.redirect = 1'b0;
    n_tests++;
    if (bus.fetch_misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL misaligned_clear: flag=%b, required 0", bus.fetch_misaligned);
    end
  endtask
`endif

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    hs_count = 0;
    mem_cnt  = 0;
    pc_m     = '0;
    prev_pc  = '0;
    out_addr = '0;
    req_prev = 1'b0;
    discard  = 1'b0;
    pw_s     = 1'b0;
    pn_s     = '0;
    test_reset();
    test_first_fetch();
    test_wait_states();
    test_stall();
    test_back_to_back();
    test_redirect_drain();
    test_redirect_ack();
    test_squash();
    test_wrap();
`ifdef IFU_ALIGN_CHECK_EN
    test_align();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
